fetch_stage: RTL

- IF stage and IF/ID pipeline register for the RV32I core.
- Generates fetch PCs, issues requests on a pipelined instruction-memory req/gnt/rvalid bus, and buffers returned words in a small prefetch FIFO.
- Presents InstrD/PCD/PCPlus4D to decode.
- Consumes StallF, StallD and FlushD from the hazard unit, plus the execute-stage redirect PCSrcE/PCTargetE.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, canonical NOP, default reset PC
// and the layout of one prefetch-buffer entry.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {PC, instruction} pairs between instruction memory
// and the IF/ID register; clear takes priority over push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so stale
    // entries are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage plus IF/ID register: pipelined imem requests, prefetch FIFO,
// redirect drop counting. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            InstrMisalignD
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  target_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             misalign_flag;
    logic             handshake;
    logic             keep;
    logic             issue_ok;
    logic             load_d;
    logic             push;
    logic             pop;
    logic             bypass;

    // Requests are throttled so every granted word is guaranteed a FIFO slot.
    assign issue_ok = (({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH))
                   && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign ImemReq  = !RST && !PCSrcE && !StallF && !misalign_flag && issue_ok;
    assign ImemAddr = pc;

    assign handshake        = ImemReq && ImemGnt;
    assign outstanding_next = outstanding + CNT_W'(handshake) - CNT_W'(ImemRvalid);
    assign keep             = ImemRvalid && (drop == '0) && !PCSrcE;
    assign load_d           = !RST && !FlushD && !StallD && !misalign_flag;
    assign push_entry       = '{pc: resp_pc, instr: ImemRdata};

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pop    = 1'b0;
        bypass = 1'b0;
        push   = 1'b0;
        if (load_d && !fifo_empty) begin
            pop = 1'b1;
        end else if (load_d && keep) begin
            bypass = 1'b1;
        end
        if (keep && !bypass) begin
            push = 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (PCSrcE),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (PCSrcE) begin
                pc      <= target_pc;
                resp_pc <= target_pc;
                drop    <= outstanding_next;
            end else begin
                if (handshake)                   pc      <= pc_plus4(pc);
                if (keep)                        resp_pc <= pc_plus4(resp_pc);
                if (ImemRvalid && drop != '0)    drop    <= drop - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= 32'd4;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (misalign_flag) begin
                InstrD   <= NOP_INSTR;
                PCD      <= pc;
                PCPlus4D <= pc_plus4(pc);
                ValidD   <= 1'b0;
            end else if (pop) begin
                InstrD   <= fifo_head.instr;
                PCD      <= fifo_head.pc;
                PCPlus4D <= pc_plus4(fifo_head.pc);
                ValidD   <= 1'b1;
            end else if (bypass) begin
                InstrD   <= ImemRdata;
                PCD      <= resp_pc;
                PCPlus4D <= pc_plus4(resp_pc);
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // The PC freezes at the misaligned target while the flag blocks issue.
    assign target_pc = PCTargetE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_flag  <= 1'b0;
            InstrMisalignD <= 1'b0;
        end else begin
            if (PCSrcE) misalign_flag <= (PCTargetE[1:0] != 2'b00);
            if (FlushD) begin
                InstrMisalignD <= 1'b0;
            end else if (!StallD) begin
                InstrMisalignD <= misalign_flag;
            end
        end
    end
`else
    assign target_pc     = PCTargetE & 32'hFFFF_FFFC;
    assign misalign_flag = 1'b0;
`endif

    assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full && !PCSrcE))
        else $error("prefetch FIFO overflow");

endmodule
